// File: rtl/ternary_pkg.sv
// Shared types and constants for the ternary (BitNet-1.58) selector datapath.
package ternary_pkg;

  typedef logic signed [1:0] trit_t;

  localparam trit_t TRIT_POS  = 2'b01;
  localparam trit_t TRIT_ZERO = 2'b00;
  localparam trit_t TRIT_NEG  = 2'b11;
  localparam trit_t TRIT_RSVD = 2'b10;

  localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/ternary_demux_lane.sv
// One lane: trit-controlled select of A, B or zero, then a single result register.
module ternary_demux_lane
  import ternary_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  trit_t                    ctrl,
  output logic signed [DATA_W-1:0] y
);

  // Reserved code -2 selects zero like 0; B is forwarded verbatim, never derived from A.
  function automatic logic signed [DATA_W-1:0] trit_sel(
    input trit_t                    c,
    input logic signed [DATA_W-1:0] av,
    input logic signed [DATA_W-1:0] bv
  );
    return ((c == TRIT_ZERO) || (c == TRIT_RSVD)) ? '0 :
           (c == TRIT_POS) ? av : bv;
  endfunction

  logic signed [DATA_W-1:0] sel_p0;
  logic signed [DATA_W-1:0] y_p1;

  always_comb sel_p0 = trit_sel(ctrl, a, b);

  // stage p0 -> p1: registered lane result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_p1 <= '0;
    else        y_p1 <= sel_p0;
  end

  assign y = y_p1;

endmodule

// File: rtl/ternary_demuxer_array.sv
// Array of independent ternary selector lanes feeding the adder tree; slices the packed buses.
module ternary_demuxer_array
  import ternary_pkg::*;
#(
  parameter int N_LANES = 4096,
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int CTRL_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_LANES*DATA_W-1:0]   a_list,
  input  logic [N_LANES*DATA_W-1:0]   b_list,
  input  logic [N_LANES*CTRL_W-1:0]   control_list,
  output logic [N_LANES*DATA_W-1:0]   y_list
);

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic signed [DATA_W-1:0] y_lane;

    ternary_demux_lane #(.DATA_W(DATA_W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .a    (signed'(a_list[i*DATA_W +: DATA_W])),
      .b    (signed'(b_list[i*DATA_W +: DATA_W])),
      .ctrl (trit_t'(control_list[i*CTRL_W +: CTRL_W])),
      .y    (y_lane)
    );

    assign y_list[i*DATA_W +: DATA_W] = y_lane;
  end

endmodule

// File: tb/tb_ternary_demuxer_array.sv
// Randomized self-checking bench for ternary_demuxer_array against a lane-level reference model.
module tb_ternary_demuxer_array;

  localparam int N  = 4096;
  localparam int DW = 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*DW-1:0] a_list;
  logic [N*DW-1:0] b_list;
  logic [N*CW-1:0] control_list;
  logic [N*DW-1:0] y_list;

  logic signed [DW-1:0] a_m [N];
  logic signed [DW-1:0] b_m [N];
  logic signed [1:0]    c_m [N];
  logic        [DW-1:0] ey  [N];

  int num_checks = 0;
  int num_errors = 0;

  ternary_demuxer_array #(.N_LANES(N), .DATA_W(DW), .CTRL_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_list      (a_list),
    .b_list      (b_list),
    .control_list(control_list),
    .y_list      (y_list)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: +1 -> A, -1 -> B, anything else -> 0
  function automatic int ref_sel(input int c, input int a, input int b);
    if (c == 1)  return a;
    if (c == -1) return b;
    return 0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      a_list[i*DW +: DW]       = a_m[i];
      b_list[i*DW +: DW]       = b_m[i];
      control_list[i*CW +: CW] = c_m[i];
    end
  endtask

  task automatic randomize_inputs(input bit allow_rsvd);
    for (int i = 0; i < N; i++) begin
      a_m[i] = DW'($urandom);
      b_m[i] = -a_m[i];
      c_m[i] = 2'($urandom);
      if (!allow_rsvd && c_m[i] == 2'b10) c_m[i] = 2'b01;
    end
  endtask

  task automatic clear_expected();
    for (int i = 0; i < N; i++) ey[i] = '0;
  endtask

  // Drive current model inputs, take one edge, update the expected registers
  task automatic step();
    drive();
    @(posedge clk);
    if (rst_n)
      for (int i = 0; i < N; i++) ey[i] = DW'(ref_sel(c_m[i], a_m[i], b_m[i]));
    #1;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s y[%0d]", tag, i), y_list[i*DW +: DW], ey[i]);
  endtask

  initial begin
    // Reset with random inputs, before any clock edge
    rst_n = 1'b0;
    randomize_inputs(1'b1);
    drive();
    clear_expected();
    #2;
    check_all("reset_noedge");
    step();
    check_all("reset_held");

    // Release between edges; lane 0 row shows up only after the next edge
    rst_n = 1'b1;
    randomize_inputs(1'b1);
    a_m[0] = 8'h24; b_m[0] = 8'hDC; c_m[0] = 2'b01;
    drive();
    #1;
    chk("release_before_edge y[0]", y_list[0 +: DW], 8'h00);
    step();
    chk("release_first_edge y[0]", y_list[0 +: DW], 8'h24);
    check_all("release");

    // Mixed sweep of -1 / 0 / +1 regions
    for (int i = 0; i < N; i++) begin
      a_m[i] = DW'($urandom);
      b_m[i] = -a_m[i];
      c_m[i] = (i <= 1365) ? 2'b11 : (i <= 2731) ? 2'b00 : 2'b01;
    end
    step();
    check_all("sweep");

    // Boundary values
    randomize_inputs(1'b1);
    a_m[0] = 8'h80; b_m[0] = 8'h80;   c_m[0] = 2'b01;
    a_m[1] = 8'sd127; b_m[1] = -8'sd127; c_m[1] = 2'b11;
    a_m[2] = 8'sd5;  b_m[2] = -8'sd5;  c_m[2] = 2'b10;
    step();
    chk("bound_min y[0]", y_list[0*DW +: DW], 8'h80);
    chk("bound_neg y[1]", y_list[1*DW +: DW], 8'h81);
    chk("bound_rsvd y[2]", y_list[2*DW +: DW], 8'h00);
    check_all("bound");

    // Back-to-back control changes on lane 4095, one-cycle latency, no bubbles
    a_m[N-1] = 8'sd7; b_m[N-1] = -8'sd7;
    begin
      logic [1:0] seq_c [4];
      logic [DW-1:0] seq_y [4];
      seq_c = '{2'b01, 2'b11, 2'b00, 2'b01};
      seq_y = '{8'h07, 8'hF9, 8'h00, 8'h07};
      for (int k = 0; k < 4; k++) begin
        c_m[N-1] = seq_c[k];
        drive();
        if (k > 0) chk($sformatf("lat_hold%0d", k), y_list[(N-1)*DW +: DW], seq_y[k-1]);
        step();
        chk($sformatf("lat_seq%0d", k), y_list[(N-1)*DW +: DW], seq_y[k]);
      end
    end

    // Mid-stream asynchronous reset
    a_m[10] = 8'h33; c_m[10] = 2'b01;
    step();
    chk("mid_pre y[10]", y_list[10*DW +: DW], 8'h33);
    rst_n = 1'b0;
    clear_expected();
    #1;
    check_all("mid_reset");
    #1;
    rst_n = 1'b1;
    randomize_inputs(1'b1);
    drive();
    #1;
    chk("mid_release_noedge y[10]", y_list[10*DW +: DW], 8'h00);
    step();
    check_all("mid_post");

    // Lane independence: walking +1, all others zero-controlled with nonzero data
    for (int i = 0; i < N; i++) begin
      a_m[i] = DW'($urandom_range(1, 127));
      b_m[i] = -a_m[i];
      c_m[i] = 2'b00;
    end
    begin
      int walk [6];
      walk = '{0, 1, 10, 2047, $urandom_range(0, N-1), N-1};
      for (int k = 0; k < 6; k++) begin
        for (int i = 0; i < N; i++) c_m[i] = 2'b00;
        c_m[walk[k]] = 2'b01;
        step();
        check_all($sformatf("walk%0d", k));
      end
    end

    // Free-running random vectors including the reserved code
    for (int k = 0; k < 6; k++) begin
      randomize_inputs(1'b1);
      for (int i = 0; i < N; i += 97) b_m[i] = DW'($urandom);
      step();
      check_all($sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
